// File: rtl/ovl_decrement_checker.sv
// ovl_decrement_checker
// Watches test_expr and flags any change that is not a decrement by exactly
// VALUE, modulo 2^WIDTH. An unchanged value is always legal. The first
// sample after reset only becomes the reference value and is never checked.
// Outputs are registered: fire[0] pulses once per violation, fire[2] pulses
// once per legal decrement (when coverage is on), and fire[1] is unused.
// err_count counts violations since reset and sticks at its maximum value.
module ovl_decrement_checker #(
  parameter int SEVERITY_LEVEL = 1,
  parameter int WIDTH          = 1,
  parameter int VALUE          = 1,
  parameter     MSG            = "VIOLATION",
  parameter int COVERAGE_LEVEL = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] test_expr,
  output logic [2:0]       fire,
  output logic [15:0]      err_count
);

  // VALUE is reduced to WIDTH bits, so the compare wraps the same way the
  // subtraction does (e.g. WIDTH=4, VALUE=1 makes 0 -> 15 legal).
  localparam logic [63:0]      VALUE_64  = 64'(VALUE);
  localparam logic [WIDTH-1:0] VALUE_MOD = VALUE_64[WIDTH-1:0];
  localparam bit               COV_ON    = (COVERAGE_LEVEL != 0);

  logic [WIDTH-1:0] prev;
  logic             prev_vld;
  logic [WIDTH-1:0] diff;
  logic             changed;
  logic             check_active;
  logic             violation;
  logic             legal_change;

  assign diff         = prev - test_expr;
  assign changed      = (test_expr != prev);
  assign check_active = enable && prev_vld;
  assign violation    = check_active && changed && (diff != VALUE_MOD);
  assign legal_change = check_active && changed && (diff == VALUE_MOD);

  // Reference tracking, registered fire pulses and the saturating error count.
  // Reset wins over everything else on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev      <= '0;
      prev_vld  <= 1'b0;
      fire      <= 3'b000;
      err_count <= 16'h0000;
    end else begin
      prev     <= test_expr;
      prev_vld <= 1'b1;
      fire     <= {COV_ON && legal_change, 1'b0, violation};
      if (violation && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'h0001;
      end
    end
  end

`ifndef SYNTHESIS
  // Simulation-only report of each violation, tagged with the severity;
  // a FATAL checker stops the simulation after the message.
  always_ff @(posedge clock) begin
    if (!reset && violation) begin
      case (SEVERITY_LEVEL)
        0:       $display("OVL_FATAL : OVL_DECREMENT : %s : time %0t", MSG, $time);
        1:       $display("OVL_ERROR : OVL_DECREMENT : %s : time %0t", MSG, $time);
        2:       $display("OVL_WARNING : OVL_DECREMENT : %s : time %0t", MSG, $time);
        default: $display("OVL_INFO : OVL_DECREMENT : %s : time %0t", MSG, $time);
      endcase
      if (SEVERITY_LEVEL == 0) begin
        $finish;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ovl_decrement_checker.sv
// tb_ovl_decrement_checker
// Directed bench for ovl_decrement_checker with WIDTH=4, VALUE=1. Each step
// drives inputs on the falling edge and samples outputs 1 time unit after
// the following rising edge. A second instance with coverage disabled
// shares the same inputs to show fire[2] stays low there.
module tb_ovl_decrement_checker;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [3:0]  test_expr;
  logic [2:0]  fire;
  logic [15:0] err_count;
  logic [2:0]  fire_nocov;
  logic [15:0] err_count_nocov;

  int checks;
  int failures;

  ovl_decrement_checker #(
    .SEVERITY_LEVEL(1),
    .WIDTH(4),
    .VALUE(1),
    .MSG("VIOLATION"),
    .COVERAGE_LEVEL(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .test_expr(test_expr),
    .fire(fire),
    .err_count(err_count)
  );

  ovl_decrement_checker #(
    .SEVERITY_LEVEL(1),
    .WIDTH(4),
    .VALUE(1),
    .MSG("NOCOV"),
    .COVERAGE_LEVEL(0)
  ) dut_nocov (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .test_expr(test_expr),
    .fire(fire_nocov),
    .err_count(err_count_nocov)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Drive one set of inputs for one rising edge, then settle past the edge.
  task automatic applyStimulus(input logic rst, input logic en, input logic [3:0] val);
    @(negedge clock);
    reset     = rst;
    enable    = en;
    test_expr = val;
    @(posedge clock);
    #1;
  endtask

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Step then check both outputs of the main instance.
  task automatic stepCheck(input string tag, input logic rst, input logic en, input logic [3:0] val,
                           input logic [2:0] exp_fire, input logic [15:0] exp_err);
    applyStimulus(rst, en, val);
    checkOutput({tag, ".fire"}, {13'd0, fire}, {13'd0, exp_fire});
    checkOutput({tag, ".err"}, err_count, exp_err);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    enable    = 1'b1;
    test_expr = 4'd0;

    // Reset held for 4 cycles while test_expr moves: nothing fires.
    stepCheck("rst0", 1'b1, 1'b1, 4'd1, 3'b000, 16'd0);
    stepCheck("rst1", 1'b1, 1'b1, 4'd2, 3'b000, 16'd0);
    stepCheck("rst2", 1'b1, 1'b1, 4'd0, 3'b000, 16'd0);
    stepCheck("rst3", 1'b1, 1'b1, 4'd0, 3'b000, 16'd0);

    // 8 is the unchecked reference, 8->6 violates, 6->5 is legal, hold is quiet.
    stepCheck("ref8",  1'b0, 1'b1, 4'd8, 3'b000, 16'd0);
    stepCheck("d8to6", 1'b0, 1'b1, 4'd6, 3'b001, 16'd1);
    stepCheck("d6to5", 1'b0, 1'b1, 4'd5, 3'b100, 16'd1);
    stepCheck("hold5", 1'b0, 1'b1, 4'd5, 3'b000, 16'd1);

    // Legal chain down through zero and wrapping to 15.
    stepCheck("d5to4",  1'b0, 1'b1, 4'd4,  3'b100, 16'd1);
    stepCheck("d4to3",  1'b0, 1'b1, 4'd3,  3'b100, 16'd1);
    stepCheck("d3to2",  1'b0, 1'b1, 4'd2,  3'b100, 16'd1);
    stepCheck("d2to1",  1'b0, 1'b1, 4'd1,  3'b100, 16'd1);
    stepCheck("d1to0",  1'b0, 1'b1, 4'd0,  3'b100, 16'd1);
    checkOutput("nocov.fire2", {15'd0, fire_nocov[2]}, 16'd0);
    stepCheck("wrap0to15", 1'b0, 1'b1, 4'd15, 3'b100, 16'd1);

    // Disabled steps are not checked; re-enabled 9->8 is legal.
    stepCheck("dis15to5", 1'b0, 1'b0, 4'd5, 3'b000, 16'd1);
    stepCheck("dis5to9",  1'b0, 1'b0, 4'd9, 3'b000, 16'd1);
    stepCheck("en9to8",   1'b0, 1'b1, 4'd8, 3'b100, 16'd1);

    // Increment 4->7 violates once, holding 7 stays quiet.
    stepCheck("dis8to4", 1'b0, 1'b0, 4'd4, 3'b000, 16'd1);
    stepCheck("inc4to7", 1'b0, 1'b1, 4'd7, 3'b001, 16'd2);
    stepCheck("hold7",   1'b0, 1'b1, 4'd7, 3'b000, 16'd2);
    // Decrement by the wrong amount, back-to-back violations.
    stepCheck("d7to5", 1'b0, 1'b1, 4'd5, 3'b001, 16'd3);
    stepCheck("d5to3", 1'b0, 1'b1, 4'd3, 3'b001, 16'd4);

    // Mid-run reset clears the count; 10 is the new unchecked reference.
    stepCheck("midrst",  1'b1, 1'b1, 4'd3,  3'b000, 16'd0);
    stepCheck("ref10",   1'b0, 1'b1, 4'd10, 3'b000, 16'd0);
    stepCheck("d10to9",  1'b0, 1'b1, 4'd9,  3'b100, 16'd0);

    // Saturation: alternate 0/5 so every change violates.
    stepCheck("satrst", 1'b1, 1'b1, 4'd0, 3'b000, 16'd0);
    stepCheck("satref", 1'b0, 1'b1, 4'd0, 3'b000, 16'd0);
    for (int i = 0; i < 65534; i++) begin
      applyStimulus(1'b0, 1'b1, (i % 2 == 0) ? 4'd5 : 4'd0);
    end
    checkOutput("sat.almost", err_count, 16'hFFFE);
    stepCheck("sat.max",   1'b0, 1'b1, 4'd5, 3'b001, 16'hFFFF);
    stepCheck("sat.stick", 1'b0, 1'b1, 4'd0, 3'b001, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ovl_decrement_checker.md
OVL_DECREMENT_CHECKER -- requirements
Module: ovl_decrement_checker

Interface
REQ-001 SHALL have parameter SEVERITY_LEVEL, default 1 (ERROR); 0=FATAL, 1=ERROR, 2=WARNING, 3=INFO; selects the simulation message tag.
REQ-002 SHALL have parameter WIDTH, default 1; bit width of test_expr, legal range 1..64.
REQ-003 SHALL have parameter VALUE, default 1; the exact decrement amount a change of test_expr must show.
REQ-004 SHALL have parameter MSG, default "VIOLATION"; text appended to the failure message.
REQ-005 SHALL have parameter COVERAGE_LEVEL, default 1; 0 disables fire[2], nonzero enables it.
REQ-006 SHALL have port clock, input, 1 bit: sole clock, all state updates on the rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port enable, input, 1 bit: 1 = checking active, 0 = checking suppressed.
REQ-009 SHALL have port test_expr, input, WIDTH bits: the monitored value.
REQ-010 SHALL have port fire, output, 3 bits, registered: [0] assertion failure, [1] X/Z check (tied 0), [2] coverage (valid decrement seen).
REQ-011 SHALL have port err_count, output, 16 bits: saturating count of assertion failures since reset.

Function
REQ-012 SHALL hold internal registers prev (WIDTH bits) and prev_vld (1 bit); each rising edge out of reset, prev<=test_expr and prev_vld<=1, regardless of enable.
REQ-013 SHALL declare a violation on an edge when reset=0, enable=1, prev_vld=1, test_expr!=prev and (prev - test_expr) mod 2^WIDTH != VALUE mod 2^WIDTH.
REQ-014 SHALL treat an unchanged test_expr as legal and raise no fire bit.
REQ-015 SHALL permit wrap-around: with WIDTH=4, VALUE=1, a change 0 -> 15 is a legal decrement.
REQ-016 SHALL treat any increment or any decrement by an amount other than VALUE as a violation.
REQ-017 SHALL set fire[0] to 1 for exactly one cycle after each violating edge, and to 0 otherwise; back-to-back violations give back-to-back pulses.
REQ-018 SHALL set fire[2] to 1 for one cycle after each legal change (reset=0, enable=1, prev_vld=1, changed, difference==VALUE) when COVERAGE_LEVEL!=0.
REQ-019 SHALL tie fire[1] to 0.
REQ-020 SHALL increment err_count on each violation and saturate at 16'hFFFF.
REQ-021 SHALL, in simulation only, print "OVL_<SEVERITY> : OVL_DECREMENT : <MSG> : time <t>" on each violation, and call $finish after the message when SEVERITY_LEVEL=0.
REQ-022 SHALL perform no check on the first edge after reset deassertion (prev_vld=0), since no reference value exists.
REQ-023 SHALL give reset priority over all other inputs on the same edge.

Reset
REQ-024 SHALL, on an edge with reset=1, clear prev, prev_vld, fire and err_count to 0.
REQ-025 SHALL not check or report while reset=1, whatever test_expr does.
REQ-026 SHALL handle reset mid-operation the same way: state cleared, first post-reset sample becomes the new reference without a check.

Verification
REQ-027 Set WIDTH=4. Hold reset=1 for 4 cycles while test_expr goes 1, 2, 0 -> fire=0 and err_count=0 throughout.
REQ-028 Release reset, then test_expr=8, then 6, then 5, then hold -> exactly one fire[0] pulse after the 8->6 edge, fire[2] pulse after the 6->5 edge, final err_count=1, one OVL_ERROR message.
REQ-029 Apply 3, 2, 1, 0, 15 with VALUE=1 -> fire[2] pulses four times, fire[0] stays 0.
REQ-030 Set enable=0 during a 5->9 step, then enable=1 for 9->8 -> no fire[0], and fire[2] pulses for 9->8.
REQ-031 Apply 4->7 (increment), then 7->7 held -> one fire[0] pulse only, err_count increments by 1.
REQ-032 Assert reset for 1 cycle after a violation, then apply 10->9 -> err_count reads 0 after reset; the first sample (10) is not checked; fire[2] pulses for 9.
